mdu_unit: RTL and testbench

//  Multiply/divide unit in the E stage, beside the ALU. Owns the HI/LO registers;

---
 rtl/mdu_unit_if.sv | 14 +
 rtl/mdu_unit.sv | 141 ++++++++++++++
 tb/tb_mdu_unit.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_unit_if.sv
// Issue/result bundle between the E stage and the multiply/divide unit.
// The master side issues ops; the slave side (the MDU) returns busy and HI/LO.
interface mdu_unit_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, a, b, input busy, hi, lo);
  modport slave  (input start, op, a, b, output busy, hi, lo);
endinterface

// File: rtl/mdu_unit.sv
// E-stage multiply/divide unit owning HI/LO: fixed-latency mult/div, single-cycle mthi/mtlo.
// Define MDU_MADD_EN to enable MADD/MADDU accumulate; otherwise ops 6/7 are ignored.
module mdu_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic       clk,
  input logic       reset,
  mdu_unit_if.slave bus
);

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_MADD  = 3'd6,
    OP_MADDU = 3'd7
  } op_e;

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  logic [3:0]  cnt;
  op_e         op_q;
  op_e         op_in;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic        wr_en;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        signed_div;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_div;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic        q_neg;
  logic        r_neg;

  assign op_in   = op_e'(bus.op);
  assign bus.busy = (cnt != '0);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      op_q <= OP_MULT;
      a_q  <= '0;
      b_q  <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else if (cnt != '0) begin
      // start is ignored for the whole busy window, including the completion edge
      cnt <= cnt - 4'd1;
      if (cnt == 4'd1 && wr_en) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end
    end else if (bus.start) begin
      case (op_in)
        OP_MTHI: hi_q <= bus.a;
        OP_MTLO: lo_q <= bus.a;
        OP_MULT, OP_MULTU: begin
          op_q <= op_in;
          a_q  <= bus.a;
          b_q  <= bus.b;
          cnt  <= MULT_CNT;
        end
        OP_DIV, OP_DIVU: begin
          op_q <= op_in;
          a_q  <= bus.a;
          b_q  <= bus.b;
          cnt  <= DIV_CNT;
        end
`ifdef MDU_MADD_EN
        OP_MADD, OP_MADDU: begin
          op_q <= op_in;
          a_q  <= bus.a;
          b_q  <= bus.b;
          cnt  <= MULT_CNT;
        end
`endif
        default: ;
      endcase
    end
  end

  // Signed divide runs on magnitudes; |0x80000000| stays 0x80000000 as unsigned,
  // so the INT_MIN / -1 case falls out as quotient 0x80000000, remainder 0.
  always_comb begin
    prod_s     = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    prod_u     = {32'd0, a_q} * {32'd0, b_q};
    signed_div = (op_q == OP_DIV);
    a_mag      = (signed_div && a_q[31]) ? -a_q : a_q;
    b_mag      = (signed_div && b_q[31]) ? -b_q : b_q;
    b_div      = (b_mag == '0) ? 32'd1 : b_mag;
    q_mag      = a_mag / b_div;
    r_mag      = a_mag % b_div;
    q_neg      = signed_div && (a_q[31] ^ b_q[31]);
    r_neg      = signed_div && a_q[31];
    wr_en      = 1'b0;
    res_hi     = hi_q;
    res_lo     = lo_q;
    case (op_q)
      OP_MULT: begin
        wr_en            = 1'b1;
        {res_hi, res_lo} = prod_s;
      end
      OP_MULTU: begin
        wr_en            = 1'b1;
        {res_hi, res_lo} = prod_u;
      end
      OP_DIV, OP_DIVU: begin
        wr_en  = (b_q != '0);
        res_lo = q_neg ? -q_mag : q_mag;
        res_hi = r_neg ? -r_mag : r_mag;
      end
`ifdef MDU_MADD_EN
      OP_MADD: begin
        wr_en            = 1'b1;
        {res_hi, res_lo} = {hi_q, lo_q} + prod_s;
      end
      OP_MADDU: begin
        wr_en            = 1'b1;
        {res_hi, res_lo} = {hi_q, lo_q} + prod_u;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: directed vector table, hand-written corner sequences,
// and random ops against a 64-bit arithmetic model (honours MDU_MADD_EN).
module tb_mdu_unit;
  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  logic clk;
  logic reset;
  mdu_unit_if bus ();

  mdu_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned vectors;
  int unsigned miscompares;
  logic [31:0] mh;
  logic [31:0] ml;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int unsigned cyc;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int unsigned exp_cycles(input logic [2:0] op);
    case (op)
      3'd0, 3'd1: return MC;
      3'd2, 3'd3: return DC;
`ifdef MDU_MADD_EN
      3'd6, 3'd7: return MC;
`endif
      default:    return 0;
    endcase
  endfunction

  task automatic model_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          x, y, q, r;
    longint unsigned ux, uy, p;
    x  = longint'($signed(a));
    y  = longint'($signed(b));
    ux = longint'({32'd0, a});
    uy = longint'({32'd0, b});
    case (op)
      3'd0: begin q = x * y;   {mh, ml} = q; end
      3'd1: begin p = ux * uy; {mh, ml} = p; end
      3'd2: if (b != 0) begin q = x / y; r = x % y; ml = q[31:0]; mh = r[31:0]; end
      3'd3: if (b != 0) begin p = ux / uy; ml = p[31:0]; p = ux % uy; mh = p[31:0]; end
      3'd4: mh = a;
      3'd5: ml = a;
`ifdef MDU_MADD_EN
      3'd6: begin q = x * y;   p = {mh, ml}; p = p + q;  {mh, ml} = p; end
      3'd7: begin p = ux * uy; q = {mh, ml}; q = q + p;  {mh, ml} = q; end
`endif
      default: ;
    endcase
  endtask

  // Issue one op, then count busy cycles (bounded) until the unit is idle again.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int unsigned cyc);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 40) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 10));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned cyc;
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    vectors     = 0;
    miscompares = 0;
    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.a     = '0;
    bus.b     = '0;

    // Reset with a MULT request held on the same edge: nothing may start.
    reset = 1'b1;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 3'd0;
    bus.a     = 32'd3;
    bus.b     = 32'd3;
    @(negedge clk);
    reset     = 1'b0;
    bus.start = 1'b0;
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_hilo", {bus.hi, bus.lo}, 64'd0);
    @(negedge clk);
    check("reset_start_ignored", {31'd0, bus.busy, bus.hi, bus.lo}, 64'd0);
    mh = '0;
    ml = '0;

    tbl[0]  = '{3'd4, 32'h11,        32'h0,        32'h11,        32'h0,        0};
    tbl[1]  = '{3'd5, 32'h22,        32'h0,        32'h11,        32'h22,       0};
    tbl[2]  = '{3'd3, 32'd5,         32'd0,        32'h11,        32'h22,       DC};
    tbl[3]  = '{3'd0, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, MC};
    tbl[4]  = '{3'd1, 32'hFFFF_FFFE, 32'd3,        32'h2,         32'hFFFF_FFFA, MC};
    tbl[5]  = '{3'd2, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, DC};
    tbl[6]  = '{3'd3, 32'd7,         32'd2,        32'h1,         32'h3,        DC};
    tbl[7]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        32'h8000_0000, DC};
    tbl[8]  = '{3'd4, 32'hABCD_0000, 32'h0,        32'hABCD_0000, 32'h8000_0000, 0};
    tbl[9]  = '{3'd4, 32'h0,         32'h0,        32'h0,         32'h8000_0000, 0};
    tbl[10] = '{3'd5, 32'hFFFF_FFFF, 32'h0,        32'h0,         32'hFFFF_FFFF, 0};
`ifdef MDU_MADD_EN
    tbl[11] = '{3'd7, 32'd1,         32'd1,        32'h1,         32'h0,        MC};
`else
    tbl[11] = '{3'd7, 32'd1,         32'd1,        32'h0,         32'hFFFF_FFFF, 0};
`endif

    foreach (tbl[i]) begin
      do_op(tbl[i].op, tbl[i].a, tbl[i].b, cyc);
      model_apply(tbl[i].op, tbl[i].a, tbl[i].b);
      check($sformatf("tbl%0d_cycles", i), 64'(cyc), 64'(tbl[i].cyc));
      check($sformatf("tbl%0d_hilo", i), {bus.hi, bus.lo}, {tbl[i].hi, tbl[i].lo});
    end

    // MTLO while a MULT is in flight is dropped.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd0; bus.a = 32'h1234; bus.b = 32'h10;
    @(negedge clk);
    bus.op = 3'd5; bus.a = 32'hDEAD;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 40) begin cyc++; @(negedge clk); end
    model_apply(3'd0, 32'h1234, 32'h10);
    check("mtlo_in_busy", {bus.hi, bus.lo}, {mh, ml});

    // Start held across the completion edge: ignored there, accepted one cycle later.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd0; bus.a = 32'h1_0000; bus.b = 32'h1_0000;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    while (cyc < MC) begin cyc++; @(negedge clk); end
    check("edge_busy_before", 64'(bus.busy), 64'd1);
    bus.start = 1'b1; bus.op = 3'd4; bus.a = 32'h5555;
    @(negedge clk);
    model_apply(3'd0, 32'h1_0000, 32'h1_0000);
    check("edge_start_ignored", {31'd0, bus.busy, bus.hi}, {32'd0, mh});
    @(negedge clk);
    bus.start = 1'b0;
    model_apply(3'd4, 32'h5555, 32'h0);
    check("edge_next_accepted", {bus.hi, bus.lo}, {mh, ml});

    // Reset in the 3rd busy cycle of a DIV: no late write afterwards.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd2; bus.a = 32'd100; bus.b = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset_state", {31'd0, bus.busy, bus.hi, bus.lo}, 64'd0);
    repeat (DC + 2) @(negedge clk);
    check("midreset_no_late", {31'd0, bus.busy, bus.hi, bus.lo}, 64'd0);
    mh = '0;
    ml = '0;

    for (int unsigned n = 0; n < 200; n++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = rnd32();
      rb  = rnd32();
      do_op(rop, ra, rb, cyc);
      model_apply(rop, ra, rb);
      check($sformatf("rnd%0d_op%0d_cycles", n, rop), 64'(cyc), 64'(exp_cycles(rop)));
      check($sformatf("rnd%0d_op%0d_a%h_b%h", n, rop, ra, rb), {bus.hi, bus.lo}, {mh, ml});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
